// File: rtl/mealy_101_pattern_tx_pkg.sv
// rtl/mealy_101_pattern_tx_pkg.sv - shared types and the 101 detector step function
package mealy_101_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_state_t;
    typedef enum logic [1:0] {S0, S1, S10} det_state_t;

    // Any 1 restarts a candidate match; a 0 only advances out of S1.
    function automatic det_state_t det_next(input det_state_t s, input logic b);
        det_state_t n;
        if (b) begin
            n = S1;
        end else if (s == S1) begin
            n = S10;
        end else begin
            n = S0;
        end
        return n;
    endfunction

endpackage

// File: rtl/mealy_101_pattern_tx_if.sv
// rtl/mealy_101_pattern_tx_if.sv - serial-bit link from the pattern transmitter to a detector
interface mealy_101_pattern_tx_if;
    logic ser_out;
    logic ser_valid;

    modport master (output ser_out, output ser_valid);
    modport slave  (input  ser_out, input  ser_valid);
endinterface

// File: rtl/mealy_101_pattern_tx_ref_model.sv
// rtl/mealy_101_pattern_tx_ref_model.sv - 3-state overlapping "101" Mealy reference model
module mealy_101_ref_model
    import mealy_101_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       bit_i,
    input  logic       bit_en_i,
    output logic       hit_o,
    output det_state_t state_o
);

    det_state_t state_q;
    det_state_t cur_state;

    // A clear in the same cycle as a bit evaluates that bit from S0.
    always_comb begin
        cur_state = clr_i ? S0 : state_q;
        hit_o     = bit_en_i && bit_i && (cur_state == S10);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
        end else if (bit_en_i) begin
            state_q <= det_next(cur_state, bit_i);
        end else if (clr_i) begin
            state_q <= S0;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/mealy_101_pattern_tx.sv
// rtl/mealy_101_pattern_tx.sv - repeating MSB-first pattern transmitter with golden 101 hit model
module mealy_101_pattern_tx
    import mealy_101_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int CLK_DIV = 1,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [DATA_W-1:0]      data_i,
    input  logic [3:0]             nbits_i,
    input  logic [3:0]             repeat_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   exp_hit_o,
    output logic [CNT_W-1:0]       exp_count_o,
    mealy_101_pattern_tx_if.master ser
);

    localparam int NB_W  = $clog2(DATA_W + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    tx_state_t         state_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] shreg_q;
    logic [NB_W-1:0]   nbits_q;
    logic [NB_W-1:0]   bit_q;
    logic [3:0]        rep_q;
    logic [3:0]        frame_q;
    logic [DIV_W-1:0]  div_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic              hit_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [NB_W-1:0]   nbits_d;
    logic [DATA_W-1:0] shreg_shl;
    logic              load;
    logic              bit_en;
    logic              bit_d;
    logic              div_last;
    logic              bit_last;
    logic              frame_last;
    logic              model_hit;

    assign div_last   = (div_q == DIV_W'(CLK_DIV - 1));
    assign bit_last   = (bit_q == nbits_q - NB_W'(1));
    assign frame_last = (frame_q == rep_q);

    always_comb begin
        if (nbits_i == 4'd0 || 32'(nbits_i) > DATA_W) begin
            nbits_d = NB_W'(DATA_W);
        end else begin
            nbits_d = NB_W'(nbits_i);
        end
    end

    // bit_d is the bit that will be on the wire next cycle; the model sees it one cycle early
    // so that exp_hit lands on the first cycle that bit is presented.
    always_comb begin
        load      = (state_q == IDLE) && start_i;
        shreg_shl = shreg_q << 1;
        bit_en    = 1'b0;
        bit_d     = 1'b0;
        if (load) begin
            bit_en = 1'b1;
            bit_d  = data_i[DATA_W-1];
        end else if (state_q == SHIFT && div_last && !(bit_last && frame_last)) begin
            bit_en = 1'b1;
            bit_d  = bit_last ? word_q[DATA_W-1] : shreg_shl[DATA_W-1];
        end
    end

    mealy_101_ref_model u_ref (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (load),
        .bit_i    (bit_d),
        .bit_en_i (bit_en),
        .hit_o    (model_hit),
        .state_o  ()
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            shreg_q <= '0;
            nbits_q <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            frame_q <= '0;
            div_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            hit_q  <= model_hit;
            done_q <= 1'b0;
            if (load) begin
                cnt_q <= CNT_W'(model_hit);
            end else if (model_hit && cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        word_q  <= data_i;
                        shreg_q <= data_i;
                        nbits_q <= nbits_d;
                        rep_q   <= repeat_i;
                        bit_q   <= '0;
                        frame_q <= '0;
                        div_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (bit_last) begin
                            bit_q <= '0;
                            if (frame_last) begin
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                frame_q <= frame_q + 4'd1;
                                shreg_q <= word_q;
                            end
                        end else begin
                            bit_q   <= bit_q + NB_W'(1);
                            shreg_q <= shreg_shl;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign exp_hit_o     = hit_q;
    assign exp_count_o   = cnt_q;
    assign ser.ser_valid = valid_q;
    assign ser.ser_out   = valid_q & shreg_q[DATA_W-1];

endmodule

// File: tb/tb_mealy_101_pattern_tx.sv
// tb/tb_mealy_101_pattern_tx.sv - scoreboard bench for the 101 pattern transmitter
module tb_mealy_101_pattern_tx;

    typedef struct {
        int cyc;
        bit so;
        bit hit;
        int cnt;
    } bit_exp_t;

    typedef struct {
        int cyc;
        int cnt;
    } done_exp_t;

    logic       clk;
    logic       rst;
    logic       start_s [3];
    logic [7:0] data_s  [3];
    logic [3:0] nbits_s [3];
    logic [3:0] rep_s   [3];

    logic       v   [3];
    logic       so  [3];
    logic       hit [3];
    logic       dn  [3];
    logic       bsy [3];
    logic [7:0] cnt [3];
    logic [7:0] c0, c1;
    logic [3:0] c2;

    int cyc  = 0;
    int nvec = 0;
    int nfail = 0;

    bit_exp_t  bq [3][$];
    done_exp_t dq [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mealy_101_pattern_tx_if sif0 ();
    mealy_101_pattern_tx_if sif1 ();
    mealy_101_pattern_tx_if sif2 ();

    mealy_101_pattern_tx #(.DATA_W(8), .CLK_DIV(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start_i(start_s[0]), .data_i(data_s[0]), .nbits_i(nbits_s[0]),
        .repeat_i(rep_s[0]), .busy_o(bsy[0]), .done_o(dn[0]), .exp_hit_o(hit[0]),
        .exp_count_o(c0), .ser(sif0)
    );
    mealy_101_pattern_tx #(.DATA_W(8), .CLK_DIV(4), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start_i(start_s[1]), .data_i(data_s[1]), .nbits_i(nbits_s[1]),
        .repeat_i(rep_s[1]), .busy_o(bsy[1]), .done_o(dn[1]), .exp_hit_o(hit[1]),
        .exp_count_o(c1), .ser(sif1)
    );
    mealy_101_pattern_tx #(.DATA_W(8), .CLK_DIV(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .start_i(start_s[2]), .data_i(data_s[2]), .nbits_i(nbits_s[2]),
        .repeat_i(rep_s[2]), .busy_o(bsy[2]), .done_o(dn[2]), .exp_hit_o(hit[2]),
        .exp_count_o(c2), .ser(sif2)
    );

    assign v[0]   = sif0.ser_valid;
    assign v[1]   = sif1.ser_valid;
    assign v[2]   = sif2.ser_valid;
    assign so[0]  = sif0.ser_out;
    assign so[1]  = sif1.ser_out;
    assign so[2]  = sif2.ser_out;
    assign cnt[0] = c0;
    assign cnt[1] = c1;
    assign cnt[2] = {4'b0000, c2};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic flag(input string name);
        nvec++;
        nfail++;
        $display("FAIL %s: got event, want none", name);
    endtask

    // Expected stream: a hit is any bit that ends "101" in the continuous stream since start.
    task automatic push_run(input int d, input logic [7:0] w, input int nb, input int rp,
                            input int div, input int cmax, input int p);
        int c, count, seen;
        logic prev1, prev2, b, h;
        bit_exp_t e;
        done_exp_t de;
        c = p; count = 0; seen = 0; prev1 = 1'b0; prev2 = 1'b0;
        for (int f = 0; f <= rp; f++) begin
            for (int i = 0; i < nb; i++) begin
                b = w[7 - i];
                h = (seen >= 2) && prev2 && !prev1 && b;
                if (h && count < cmax) count++;
                for (int j = 0; j < div; j++) begin
                    e.cyc = c; e.so = b; e.hit = h && (j == 0); e.cnt = count;
                    bq[d].push_back(e);
                    c++;
                end
                prev2 = prev1; prev1 = b; seen++;
            end
        end
        de.cyc = c; de.cnt = count;
        dq[d].push_back(de);
    endtask

    task automatic launch(input int d, input logic [7:0] w, input logic [3:0] nb,
                          input logic [3:0] rp, output int p);
        @(posedge clk); #1;
        start_s[d] = 1'b1; data_s[d] = w; nbits_s[d] = nb; rep_s[d] = rp;
        @(posedge clk); #1;
        start_s[d] = 1'b0; data_s[d] = ~w; nbits_s[d] = 4'd2; rep_s[d] = 4'd7;
        p = cyc;
    endtask

    task automatic wait_done(input int d, input int budget, output int dc);
        int n;
        n = 0;
        @(negedge clk);
        while (dn[d] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dn[d] !== 1'b1) begin
            nvec++; nfail++;
            $display("FAIL done timeout dut%0d: got no done, want done within %0d cycles", d, budget);
        end
        dc = cyc;
    endtask

    always @(negedge clk) begin
        bit_exp_t e;
        done_exp_t de;
        for (int d = 0; d < 3; d++) begin
            if (v[d] === 1'b1) begin
                if (bq[d].size() == 0) begin
                    flag($sformatf("unexpected bit dut%0d cyc %0d", d, cyc));
                end else begin
                    e = bq[d].pop_front();
                    check($sformatf("bit cycle dut%0d", d), cyc, e.cyc);
                    check($sformatf("bit so/hit/busy/cnt dut%0d cyc %0d", d, cyc),
                          {so[d], hit[d], bsy[d], cnt[d]}, {e.so, e.hit, 1'b1, 8'(e.cnt)});
                end
            end else if (bq[d].size() > 0 && bq[d][0].cyc <= cyc) begin
                check($sformatf("missing bit dut%0d cyc %0d", d, cyc), v[d], 1'b1);
                void'(bq[d].pop_front());
            end
            if (dn[d] === 1'b1) begin
                if (dq[d].size() == 0) begin
                    flag($sformatf("unexpected done dut%0d cyc %0d", d, cyc));
                end else begin
                    de = dq[d].pop_front();
                    check($sformatf("done cycle dut%0d", d), cyc, de.cyc);
                    check($sformatf("done busy/valid/cnt dut%0d", d),
                          {bsy[d], v[d], cnt[d]}, {1'b0, 1'b0, 8'(de.cnt)});
                end
            end else if (dq[d].size() > 0 && dq[d][0].cyc <= cyc) begin
                check($sformatf("missing done dut%0d cyc %0d", d, cyc), dn[d], 1'b1);
                void'(dq[d].pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        int p, dc;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0; data_s[d] = 8'h00; nbits_s[d] = 4'd0; rep_s[d] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            check($sformatf("reset outputs dut%0d", d),
                  {v[d], so[d], bsy[d], dn[d], hit[d], cnt[d]}, 32'h0);

        // 1: 1010_1000, 8 bits, single frame
        launch(0, 8'b1010_1000, 4'd8, 4'd0, p);
        push_run(0, 8'b1010_1000, 8, 0, 1, 255, p);
        wait_done(0, 50, dc);
        check("t1 done latency", dc - p, 8);
        check("t1 exp_count", cnt[0], 2);

        // 2: 3-bit frame "101" sent three times, started in the IDLE cycle after DONE
        launch(0, 8'b1010_0000, 4'd3, 4'd2, p);
        push_run(0, 8'b1010_0000, 3, 2, 1, 255, p);
        wait_done(0, 50, dc);
        check("t2 done latency", dc - p, 9);
        check("t2 exp_count", cnt[0], 3);

        // 3: start pulsed during bit 4 must be ignored
        launch(0, 8'b1010_1000, 4'd8, 4'd0, p);
        push_run(0, 8'b1010_1000, 8, 0, 1, 255, p);
        while (cyc < p + 3) begin
            @(posedge clk); #1;
        end
        start_s[0] = 1'b1; data_s[0] = 8'hFF; nbits_s[0] = 4'd1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        wait_done(0, 50, dc);
        check("t3 done latency", dc - p, 8);
        check("t3 exp_count", cnt[0], 2);

        // 4: reset during bit 5, then a clean restart
        launch(0, 8'b1010_1000, 4'd8, 4'd0, p);
        push_run(0, 8'b1010_1000, 8, 0, 1, 255, p);
        while (cyc < p + 4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        while (bq[0].size() > 0 && bq[0][bq[0].size() - 1].cyc >= p + 5) void'(bq[0].pop_back());
        while (dq[0].size() > 0 && dq[0][dq[0].size() - 1].cyc >= p + 5) void'(dq[0].pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t4 post-reset valid/out/busy/done/hit", {v[0], so[0], bsy[0], dn[0], hit[0]}, 0);
        check("t4 post-reset exp_count", cnt[0], 0);
        launch(0, 8'b1010_1000, 4'd8, 4'd0, p);
        push_run(0, 8'b1010_1000, 8, 0, 1, 255, p);
        wait_done(0, 50, dc);
        check("t4 restart done latency", dc - p, 8);
        check("t4 restart exp_count", cnt[0], 2);

        // 5: CLK_DIV=4, nbits=0 means all 8 bits
        launch(1, 8'hA0, 4'd0, 4'd0, p);
        push_run(1, 8'hA0, 8, 0, 4, 255, p);
        wait_done(1, 100, dc);
        check("t5 done latency", dc - p, 32);
        check("t5 exp_count", cnt[1], 1);

        // 6: 4-bit counter saturates over 16 frames of 0xAA
        launch(2, 8'hAA, 4'd8, 4'd15, p);
        push_run(2, 8'hAA, 8, 15, 1, 15, p);
        wait_done(2, 300, dc);
        check("t6 done latency", dc - p, 128);
        check("t6 exp_count saturated", cnt[2], 15);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t6 exp_count held after done", cnt[2], 15);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("bit queue drained dut%0d", d), bq[d].size(), 0);
            check($sformatf("done queue drained dut%0d", d), dq[d].size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
